// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'd0,
      DIVU = 2'd1,
      REM  = 2'd2,
      REMU = 2'd3
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam int          DIV_ITERATIONS = 32;
   localparam logic [4:0]  LAST_ITER      = 5'(DIV_ITERATIONS - 1);
   localparam logic [31:0] INT_MIN        = 32'h8000_0000;

endpackage

// File: rtl/subtractor33.sv
// 33-bit combinational subtract with borrow, the trial step of restoring division.
module subtractor33 (
   input  logic [32:0] a,
   input  logic [32:0] b,
   output logic [32:0] diff,
   output logic        borrow_out
);

   assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/divider32.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: 32 RUN cycles, one FIX
// cycle for sign correction, and a one-cycle DONE pulse.
module divider32
   import div_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   div_state_t  state, nxt;
   div_op_t     op_in, op_q;
   logic [4:0]  cnt;
   logic [32:0] rem_q;
   logic [31:0] quo_q, dsr_q;
   logic        neg_q, neg_r;

   logic        is_signed, div_zero, overflow, special, accept;
   logic [31:0] a_abs, b_abs, spec_q, spec_r, quo_fix, rem_fix;
   logic [32:0] r_shift, sub_diff;
   logic        sub_borrow;
   logic        rem_unused;

   assign op_in     = div_op_t'(op);
   assign is_signed = (op_in == DIV) || (op_in == REM);
   assign div_zero  = (divisor == 32'd0);
   assign overflow  = is_signed && (dividend == INT_MIN) && (divisor == 32'hFFFF_FFFF);
   assign special   = div_zero || overflow;
   assign accept    = (state == IDLE) && start;

   assign a_abs = (is_signed && dividend[31]) ? ~dividend + 32'd1 : dividend;
   assign b_abs = (is_signed && divisor[31])  ? ~divisor + 32'd1  : divisor;

   // Divide-by-zero takes precedence; otherwise this is the INT_MIN / -1 case.
   assign spec_q = div_zero ? 32'hFFFF_FFFF : INT_MIN;
   assign spec_r = div_zero ? dividend : 32'd0;

   assign r_shift    = {rem_q[31:0], quo_q[31]};
   assign rem_unused = rem_q[32];

   subtractor33 u_sub (
      .a          (r_shift),
      .b          ({1'b0, dsr_q}),
      .diff       (sub_diff),
      .borrow_out (sub_borrow)
   );

   assign quo_fix = neg_q ? ~quo_q + 32'd1 : quo_q;
   assign rem_fix = neg_r ? ~rem_q[31:0] + 32'd1 : rem_q[31:0];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = special ? DONE : RUN;
         RUN:     if (cnt == LAST_ITER) nxt = FIX;
         FIX:     nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q   <= DIV;
         cnt    <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dsr_q  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
      end else if (accept) begin
         op_q  <= op_in;
         cnt   <= '0;
         rem_q <= '0;
         quo_q <= a_abs;
         dsr_q <= b_abs;
         neg_q <= is_signed && (dividend[31] ^ divisor[31]);
         neg_r <= is_signed && dividend[31];
         if (special) result <= op_in[1] ? spec_r : spec_q;
      end else if (state == RUN) begin
         cnt <= cnt + 5'd1;
         if (!sub_borrow) begin
            rem_q <= sub_diff;
            quo_q <= {quo_q[30:0], 1'b1};
         end else begin
            rem_q <= r_shift;
            quo_q <= {quo_q[30:0], 1'b0};
         end
      end else if (state == FIX) begin
         result <= (op_q == REM || op_q == REMU) ? rem_fix : quo_fix;
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
